// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared definitions for the RV32I pipelined core. Holds the
//            datapath defaults, the Result_src and ALU_op encodings, the
//            decoded-control bundle and the all-zero control constant.
// Revision : 1.0  initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RA_W_DEF = 5;

    // Result_src encodings (write-back mux select)
    localparam logic [1:0] RES_SRC_ALU = 2'b00;
    localparam logic [1:0] RES_SRC_MEM = 2'b01;
    localparam logic [1:0] RES_SRC_PC4 = 2'b10;

    // ALU_op encodings (operation class handed to the ALU decoder)
    localparam logic [2:0] ALU_OP_ADD    = 3'b000;  // loads, stores, addi
    localparam logic [2:0] ALU_OP_SUB    = 3'b001;  // branch compare
    localparam logic [2:0] ALU_OP_RTYPE  = 3'b010;  // funct3/funct7 decides
    localparam logic [2:0] ALU_OP_ITYPE  = 3'b011;  // funct3 decides
    localparam logic [2:0] ALU_OP_LUI    = 3'b100;  // pass immediate

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [1:0] result_src;
        logic [2:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Clears every control bit that could change architectural state or
    // redirect fetch; the remaining fields are left as decoded.
    function automatic ctrl_t squash_ctrl(input ctrl_t c);
        ctrl_t r;
        r           = c;
        r.reg_write = CTRL_NOP.reg_write;
        r.mem_write = CTRL_NOP.mem_write;
        r.branch    = CTRL_NOP.branch;
        r.jump      = CTRL_NOP.jump;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg
// Purpose  : Generic pipeline register with clear and enable.
//            Priority per rising edge: rst (async) > clr > en > hold.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-high reset, q -> 0
//            en   - load d into q
//            clr  - synchronous clear, q -> 0 (wins over en)
//            d    - data in  [WIDTH-1:0]
//            q    - data out [WIDTH-1:0]
// Revision : 1.0  initial release
// ============================================================================
module pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_reg
// Purpose  : Decode -> execute pipeline register of the RV32I core.
//            One-cycle latency, no combinational input->output path.
//            flush_e > stall_e > load. A load with valid_d=0 forces the
//            RegWrite/MemWrite/Branch/Jump outputs to 0 but still captures
//            the data fields.
// Ports    : clk, rst (async active-high), stall_e, flush_e, valid_d,
//            decoded controls *_d, operands/PC *_d  ->  registered *_e,
//            valid_e.
// Option   : ID_EX_PERF_CNT_EN - adds bubble_cnt / stall_cnt outputs
//            (32-bit wrapping performance counters).
// Revision : 1.0  initial release
// ============================================================================
module id_ex_stage_reg
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic            valid_d,
    input  logic            RegWrite_d,
    input  logic            ALU_src_d,
    input  logic            MemWrite_d,
    input  logic            Branch_d,
    input  logic            Jump_d,
    input  logic [1:0]      Result_src_d,
    input  logic [2:0]      ALU_op_d,
    input  logic [2:0]      funct3_d,
    input  logic            funct7b5_d,
    input  logic [XLEN-1:0] rd1_d,
    input  logic [XLEN-1:0] rd2_d,
    input  logic [XLEN-1:0] imm_ext_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_plus4_d,
    input  logic [RA_W-1:0] rs1_d,
    input  logic [RA_W-1:0] rs2_d,
    input  logic [RA_W-1:0] rd_d,
    output logic            RegWrite_e,
    output logic            ALU_src_e,
    output logic            MemWrite_e,
    output logic            Branch_e,
    output logic            Jump_e,
    output logic [1:0]      Result_src_e,
    output logic [2:0]      ALU_op_e,
    output logic [2:0]      funct3_e,
    output logic            funct7b5_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_ext_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc_plus4_e,
    output logic [RA_W-1:0] rs1_e,
    output logic [RA_W-1:0] rs2_e,
    output logic [RA_W-1:0] rd_e,
    output logic            valid_e
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]     bubble_cnt,
    output logic [31:0]     stall_cnt
`endif
);

    localparam int CTRL_W = $bits(ctrl_t);
    localparam int AUX_W  = 3 + 1 + 1;            // funct3, funct7b5, valid
    localparam int DATA_W = 5 * XLEN + 3 * RA_W;
    localparam int BUS_W  = CTRL_W + AUX_W + DATA_W;

    ctrl_t             w_ctrl_in;
    ctrl_t             w_ctrl_d;
    ctrl_t             w_ctrl_q;
    logic [BUS_W-1:0]  w_bus_d;
    logic [BUS_W-1:0]  w_bus_q;
    logic              w_en;

    assign w_ctrl_in = {RegWrite_d, ALU_src_d, MemWrite_d, Branch_d, Jump_d,
                        Result_src_d, ALU_op_d};

    // A non-instruction in decode must not write state once it reaches EX.
    assign w_ctrl_d = valid_d ? w_ctrl_in : squash_ctrl(w_ctrl_in);

    assign w_bus_d = {w_ctrl_d, funct3_d, funct7b5_d, valid_d,
                      rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d,
                      rs1_d, rs2_d, rd_d};

    assign w_en = ~stall_e;

    pipe_reg #(
        .WIDTH (BUS_W)
    ) u_bus_reg (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .clr (flush_e),
        .d   (w_bus_d),
        .q   (w_bus_q)
    );

    assign {w_ctrl_q, funct3_e, funct7b5_e, valid_e,
            rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e,
            rs1_e, rs2_e, rd_e} = w_bus_q;

    assign {RegWrite_e, ALU_src_e, MemWrite_e, Branch_e, Jump_e,
            Result_src_e, ALU_op_e} = w_ctrl_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] stall_cnt_q;

    // A bubble enters EX either through a flush or through an unstalled
    // load of an invalid decode slot. Counters wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= 32'd0;
            stall_cnt_q  <= 32'd0;
        end else begin
            if (flush_e || (!stall_e && !valid_d)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
            if (stall_e && !flush_e) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Decode→execute pipeline register of the RV32I pipelined core.
- Directly downstream of Main_Decoder and the register file / immediate extender.
- Captures decoded control (RegWrite, ALU_src, MemWrite, Result_src, Branch, ALU_op, Jump), operands and PC info each cycle; stall holds, flush inserts a bubble.
- Optionally counts bubbles and stall cycles for performance debug.

Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register-address width

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous active-high reset
- stall_e  in  1  hold all outputs (hazard unit)
- flush_e  in  1  insert bubble (branch taken / load-use)
- valid_d  in  1  decode stage holds a real instruction
- RegWrite_d, ALU_src_d, MemWrite_d, Branch_d, Jump_d  in  1 each  decoder controls
- Result_src_d  in  2  result select
- ALU_op_d  in  3  ALU operation class
- funct3_d  in  3  branch/ALU sub-op
- funct7b5_d  in  1  bit 30 of instr
- rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d  in  XLEN each
- rs1_d, rs2_d, rd_d  in  RA_W each
- each *_d input has a same-width registered *_e output; plus valid_e  out  1

Behaviour:
- Reset (async assert, sync-to-clk deassert use): every output is 0 → a bubble with RegWrite_e=0, MemWrite_e=0, Branch_e=0, Jump_e=0, valid_e=0.
- Latency: exactly 1 cycle; no combinational path from input to output.
- Per rising edge, priority flush_e > stall_e > load.
- flush_e=1: every output is 0 (control and data), valid_e=0.
- stall_e=1, flush_e=0: every output holds its value.
- Otherwise: every *_e ← *_d; valid_e ← valid_d.
- valid_d=0 on load: control outputs (RegWrite, MemWrite, Branch, Jump) forced 0. Data is still captured, so a bubble never writes state.
- Simultaneous flush and stall: flush wins.
- Stall while holding a bubble: the bubble persists.
- Reset mid-stall: outputs go to 0 immediately. The stall has no effect until rst deasserts.
- Fields are stored without decode or arithmetic; widths are passed through unchanged.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - Adds outputs bubble_cnt (32) and stall_cnt (32), both reset to 0.
  - bubble_cnt increments on each edge with flush_e=1, or with a load where valid_d=0.
  - stall_cnt increments on each edge with stall_e=1 and flush_e=0.
  - Both wrap 0xFFFFFFFF → 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package riscv_pkg holds:
  - Result_src encodings: 00 ALU, 01 memory, 10 PC+4.
  - ALU_op encodings.
  - XLEN / RA_W defaults.
  - Constant CTRL_NOP = all control bits 0.
- Sub-module pipe_reg (parameter WIDTH; ports clk, rst, en, clr, d, q) with the same priority rules.
- The stage instantiates pipe_reg once for a concatenated control+data bus. Control fields are masked by valid_d before the bus enters pipe_reg.

Test Plan:
- Reset with inputs nonzero → all outputs 0. Release rst and load sw (RegWrite_d=0, ALU_src_d=1, MemWrite_d=1, rd2_d=0x0000ABCD, imm_ext_d=0x8) → next edge MemWrite_e=1, ALU_src_e=1, rd2_e=0x0000ABCD, imm_ext_e=0x8, valid_e=1.
- Load addi (RegWrite_d=1, ALU_src_d=1, rd_d=5, imm_ext_d=0xFFFFFFFF), then stall_e=1 for 3 cycles with new inputs → outputs keep addi values for all 3 edges; update on the 4th.
- flush_e=1 together with stall_e=1 while a beq (Branch_d=1, pc_d=0x100) is presented → next edge all outputs 0, valid_e=0.
- valid_d=0 with RegWrite_d=1, MemWrite_d=1, rd1_d=0x55 → RegWrite_e=0, MemWrite_e=0, rd1_e=0x55, valid_e=0.
- Assert rst asynchronously mid-cycle during a stall → outputs 0 before the next clk edge.
- With ID_EX_PERF_CNT_EN defined: 2 flushes + 3 stalls + 1 valid_d=0 load → bubble_cnt=3, stall_cnt=3. Preload counter 0xFFFFFFFF, then one flush → bubble_cnt=0.
